axis_ft245_rx_buffer: RTL and testbench

AXIS_FT245_RX_BUFFER -- requirements
Module: axis_ft245_rx_buffer

---
 rtl/axis_ft245_rx_buffer_pkg.sv | 23 ++
 rtl/axis_ft245_fifo_mem.sv | 24 ++
 rtl/axis_ft245_rx_buffer.sv | 93 +++++++++
 tb/tb_axis_ft245_rx_buffer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/axis_ft245_rx_buffer_pkg.sv
// Shared definitions for the FT245 receive/transmit stream buffers.
// Default geometry and pointer-width helpers.
package axis_ft245_rx_buffer_pkg;

    localparam int DEF_BUS_WIDTH    = 1;
    localparam int DEF_DEPTH        = 16;
    localparam int DEF_AFULL_MARGIN = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

    // One extra bit distinguishes full from empty
    function automatic int ptr_width(input int d);
        return clog2(d) + 1;
    endfunction

endpackage

// File: rtl/axis_ft245_fifo_mem.sv
// Simple dual-port storage: synchronous write, combinational read.
// Intentionally unreset so it maps onto distributed RAM.
module axis_ft245_fifo_mem #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axis_ft245_rx_buffer.sv
// First-word-fall-through receive buffer between the FT245 read
// path and an AXI-Stream consumer, with overrun margin on tready.
module axis_ft245_rx_buffer
    import axis_ft245_rx_buffer_pkg::*;
#(
    parameter int bus_width    = DEF_BUS_WIDTH,
    parameter int depth        = DEF_DEPTH,
    parameter int afull_margin = DEF_AFULL_MARGIN
) (
    input  logic                        aclk,
    input  logic                        arst,
    input  logic [bus_width*8-1:0]      s_axis_tdata,
    input  logic [bus_width-1:0]        s_axis_tkeep,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [bus_width*8-1:0]      m_axis_tdata,
    output logic [bus_width-1:0]        m_axis_tkeep,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [ptr_width(depth)-1:0] occupancy,
    output logic                        overflow
);

    localparam int DW = bus_width * 8;
    localparam int W  = DW + bus_width;
    localparam int AW = clog2(depth);
    localparam int PW = ptr_width(depth);
    localparam logic [PW-1:0] AF_THR = PW'(depth - afull_margin);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_overflow;
    logic          r_tready;

    logic          w_full;
    logic          w_empty;
    logic          w_beat;
    logic          w_wr;
    logic          w_rd;
    logic          w_drop;
    logic [PW-1:0] w_occ;
    logic [PW-1:0] w_occ_nxt;
    logic [W-1:0]  w_rdata;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0])
                  && (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]);

    // Writes ignore tready: upstream keeps sending a few beats after it falls
    assign w_beat = s_axis_tvalid && (|s_axis_tkeep);
    assign w_rd   = !w_empty && m_axis_tready;
    assign w_wr   = w_beat && (!w_full || w_rd);
    assign w_drop = w_beat && w_full && !w_rd;

    assign w_occ     = r_wr_ptr - r_rd_ptr;
    assign w_occ_nxt = w_occ + PW'(w_wr) - PW'(w_rd);

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
            r_tready   <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_drop) r_overflow <= 1'b1;
            r_tready <= (w_occ_nxt <= AF_THR);
        end
    end

    axis_ft245_fifo_mem #(
        .WIDTH (W),
        .DEPTH (depth),
        .AW    (AW)
    ) u_mem (
        .clk     (aclk),
        .i_we    (w_wr),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata ({s_axis_tkeep, s_axis_tdata}),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rdata)
    );

    // Unreset storage is masked so an empty buffer presents zeros
    assign m_axis_tdata  = w_empty ? '0 : w_rdata[DW-1:0];
    assign m_axis_tkeep  = w_empty ? '0 : w_rdata[W-1:DW];
    assign m_axis_tvalid = !w_empty;
    assign s_axis_tready = r_tready;
    assign occupancy     = w_occ;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_axis_ft245_rx_buffer.sv
// Scoreboard bench for axis_ft245_rx_buffer (bus_width=1,
// depth=16, afull_margin=4).
module tb_axis_ft245_rx_buffer;

    logic       aclk = 1'b0;
    logic       arst = 1'b0;
    logic [7:0] s_tdata = '0;
    logic [0:0] s_tkeep = '0;
    logic       s_tvalid = 1'b0;
    logic       s_tready;
    logic [7:0] m_tdata;
    logic [0:0] m_tkeep;
    logic       m_tvalid;
    logic       m_tready = 1'b0;
    logic [4:0] occ;
    logic       ovf;

    int checks = 0;
    int errors = 0;
    logic [8:0] sb [$];

    always #5 aclk = ~aclk;

    axis_ft245_rx_buffer #(
        .bus_width    (1),
        .depth        (16),
        .afull_margin (4)
    ) dut (
        .aclk          (aclk),
        .arst          (arst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .occupancy     (occ),
        .overflow      (ovf)
    );

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted output beat must match the queue head
    always @(negedge aclk) begin
        if (!arst && m_tvalid && m_tready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got %0h expected none",
                         {m_tkeep, m_tdata});
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                if ({m_tkeep, m_tdata} !== e) begin
                    errors++;
                    $display("FAIL beat: got %0h expected %0h",
                             {m_tkeep, m_tdata}, e);
                end
            end
        end
    end

    task automatic beat(input logic [7:0] d, input logic k,
                        input bit expect_acc);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        if (expect_acc) sb.push_back({k, d});
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        s_tkeep  = '0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        m_tready = 1'b1;
        while (occ != 0 && n < budget) begin
            @(posedge aclk);
            #1;
            n++;
        end
        @(posedge aclk);
        #1;
        m_tready = 1'b0;
        chk("drain_occ", 32'(occ), 0);
        chk("drain_sb", 32'(sb.size()), 0);
    endtask

    task automatic do_reset();
        @(posedge aclk);
        #2;
        arst = 1'b1;
        #1;
        sb.delete();
        chk("rst_out", {m_tvalid, m_tdata, m_tkeep, ovf, s_tready}, 0);
        chk("rst_occ", 32'(occ), 0);
        @(posedge aclk);
        #7;
        arst = 1'b0;
        @(posedge aclk);
        #1;
        chk("rst_tready", 32'(s_tready), 1);
    endtask

    initial begin
        int sent;
        int cyc;

        // Basic pass-through with one-cycle latency
        do_reset();
        m_tready = 1'b1;
        beat(8'h11, 1'b1, 1'b1);
        chk("fwft_valid", 32'(m_tvalid), 1);
        chk("fwft_data", 32'(m_tdata), 32'h11);
        beat(8'h22, 1'b1, 1'b1);
        beat(8'h33, 1'b1, 1'b1);
        drain(10);

        // Fill past the margin, then overrun
        m_tready = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            beat(8'(k), 1'b1, k <= 16);
            if (k == 12) chk("tready_at12", 32'(s_tready), 1);
            if (k == 13) chk("tready_at13", 32'(s_tready), 0);
            if (k == 16) chk("ovf_at16", 32'(ovf), 0);
        end
        chk("ovf_set", 32'(ovf), 1);
        chk("occ_full", 32'(occ), 16);
        drain(40);
        chk("ovf_sticky", 32'(ovf), 1);

        // Simultaneous read and write while full
        do_reset();
        for (int k = 0; k < 16; k++) beat(8'h80 + 8'(k), 1'b1, 1'b1);
        chk("full_occ", 32'(occ), 16);
        m_tready = 1'b1;
        beat(8'hC5, 1'b1, 1'b1);
        m_tready = 1'b0;
        chk("rw_full_occ", 32'(occ), 16);
        chk("rw_full_ovf", 32'(ovf), 0);
        drain(40);

        // Null beats are discarded
        for (int k = 0; k < 8; k++) begin
            logic [7:0] d;
            d = 8'hA0 + 8'(k);
            beat(d, d[0], d[0]);
        end
        chk("null_occ", 32'(occ), 4);
        chk("null_ovf", 32'(ovf), 0);
        drain(20);

        // Pointer wrap under random backpressure
        sent = 0;
        cyc  = 0;
        while (sent < 40 && cyc < 400) begin
            m_tready = 1'($urandom_range(0, 1));
            if (s_tready) begin
                s_tvalid = 1'b1;
                s_tdata  = 8'(sent * 7 + 3);
                s_tkeep  = 1'b1;
                sb.push_back({1'b1, 8'(sent * 7 + 3)});
                sent++;
            end else begin
                s_tvalid = 1'b0;
                s_tkeep  = '0;
            end
            @(posedge aclk);
            #1;
            cyc++;
        end
        s_tvalid = 1'b0;
        s_tkeep  = '0;
        chk("wrap_sent", 32'(sent), 40);
        drain(60);
        chk("wrap_ovf", 32'(ovf), 0);

        // Asynchronous reset with stored beats
        for (int k = 0; k < 7; k++) beat(8'h60 + 8'(k), 1'b1, 1'b1);
        chk("pre_rst_occ", 32'(occ), 7);
        #3;
        arst = 1'b1;
        #1;
        sb.delete();
        chk("async_out", {m_tvalid, m_tdata, m_tkeep, ovf, s_tready}, 0);
        chk("async_occ", 32'(occ), 0);
        @(posedge aclk);
        #7;
        arst = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("post_rst_valid", 32'(m_tvalid), 0);
        chk("post_rst_ovf", 32'(ovf), 0);
        chk("post_rst_tready", 32'(s_tready), 1);
        m_tready = 1'b1;
        beat(8'h77, 1'b1, 1'b1);
        drain(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
